// File: rtl/mdc_copr_regs_pkg.sv
// Register map, field positions and response codes for the MDC coprocessor
// control/status block.
package mdc_copr_regs_pkg;

  // Word index within the 32-byte register window (byte address bits [4:2])
  typedef enum logic [2:0] {
    REG_CTRL      = 3'd0,
    REG_STATUS    = 3'd1,
    REG_CONFIG_ID = 3'd2,
    REG_SIZE      = 3'd3,
    REG_SRC_ADDR  = 3'd4,
    REG_DST_ADDR  = 3'd5,
    REG_VERSION   = 3'd6,
    REG_RSVD      = 3'd7
  } reg_idx_e;

  localparam logic [4:0] OFS_CTRL      = 5'h00;
  localparam logic [4:0] OFS_STATUS    = 5'h04;
  localparam logic [4:0] OFS_CONFIG_ID = 5'h08;
  localparam logic [4:0] OFS_SIZE      = 5'h0C;
  localparam logic [4:0] OFS_SRC_ADDR  = 5'h10;
  localparam logic [4:0] OFS_DST_ADDR  = 5'h14;
  localparam logic [4:0] OFS_VERSION   = 5'h18;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;

  localparam logic [1:0]  RESP_OKAY       = 2'b00;
  localparam logic [1:0]  RESP_SLVERR     = 2'b10;
  localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mdc_axil_cfg_slave.sv
// AXI4-Lite register slave for the MDC coprocessor: configuration registers,
// start pulse, sticky done status and level interrupt.
module mdc_axil_cfg_slave
  import mdc_copr_regs_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ID_W    = 8,
  parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
  input  logic              sys_clock,
  input  logic              reset_rtl,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              start_o,
  output logic [ID_W-1:0]   config_id_o,
  output logic [31:0]       size_o,
  output logic [31:0]       src_addr_o,
  output logic [31:0]       dst_addr_o,
  input  logic              done_i,
  output logic              busy_o,
  output logic              irq_o
);

  logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              start_q, start_d, busy_q, busy_d, done_q, done_d;
  logic              irq_en_q, irq_en_d, irq_q, irq_d;
  logic [ID_W-1:0]   config_id_q, config_id_d;
  logic [31:0]       size_q, size_d, src_addr_q, src_addr_d, dst_addr_q, dst_addr_d;

  logic              aw_hs, w_hs, ar_hs, wr_go, wr_err, rd_err;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd, rd_word;
  logic [3:0]        ws;
  reg_idx_e          wr_idx, rd_idx;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{wa[1:0], s_axi_araddr[1:0]};

  always_comb begin
    aw_hs  = s_axi_awvalid & awready_q;
    w_hs   = s_axi_wvalid & wready_q;
    ar_hs  = s_axi_arvalid & arready_q;
    // A beat arriving this cycle is used directly so the write lands on its edge
    wa     = aw_held_q ? awaddr_q : s_axi_awaddr;
    wd     = w_held_q ? wdata_q : s_axi_wdata;
    ws     = w_held_q ? wstrb_q : s_axi_wstrb;
    wr_go  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    wr_idx = reg_idx_e'(wa[4:2]);
    wr_err = |(wa >> 5);
    rd_idx = reg_idx_e'(s_axi_araddr[4:2]);
    rd_err = |(s_axi_araddr >> 5);

    aw_held_d   = aw_held_q;   awaddr_d   = awaddr_q;
    w_held_d    = w_held_q;    wdata_d    = wdata_q;    wstrb_d = wstrb_q;
    bvalid_d    = bvalid_q;    bresp_d    = bresp_q;
    rvalid_d    = rvalid_q;    rresp_d    = rresp_q;    rdata_d = rdata_q;
    start_d     = 1'b0;        busy_d     = busy_q;     done_d  = done_q;
    irq_en_d    = irq_en_q;    config_id_d = config_id_q;
    size_d      = size_q;      src_addr_d = src_addr_q; dst_addr_d = dst_addr_q;

    if (aw_hs) begin aw_held_d = 1'b1; awaddr_d = s_axi_awaddr; end
    if (w_hs)  begin w_held_d = 1'b1; wdata_d = s_axi_wdata; wstrb_d = s_axi_wstrb; end
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;

    if (wr_go) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
      if (!wr_err) begin
        case (wr_idx)
          REG_CTRL: if (ws[0]) begin
            irq_en_d = wd[CTRL_IRQ_EN_BIT];
            if (wd[CTRL_START_BIT] && !busy_q) begin
              start_d = 1'b1;
              busy_d  = 1'b1;
            end
          end
          REG_STATUS:    if (ws[0] && wd[STAT_DONE_BIT]) done_d = 1'b0;
          REG_CONFIG_ID: config_id_d = ID_W'(strb_merge(32'(config_id_q), wd, ws));
          REG_SIZE:      size_d      = strb_merge(size_q, wd, ws);
          REG_SRC_ADDR:  src_addr_d  = strb_merge(src_addr_q, wd, ws);
          REG_DST_ADDR:  dst_addr_d  = strb_merge(dst_addr_q, wd, ws);
          default: ;
        endcase
      end
    end

    // done_i is applied after the W1C so a simultaneous set wins
    if (done_i) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    irq_d = irq_en_d & done_d;

    rd_word = 32'h0;
    case (rd_idx)
      REG_CTRL:      rd_word[CTRL_IRQ_EN_BIT] = irq_en_q;
      REG_STATUS:    rd_word = {30'h0, done_q, busy_q};
      REG_CONFIG_ID: rd_word = 32'(config_id_q);
      REG_SIZE:      rd_word = size_q;
      REG_SRC_ADDR:  rd_word = src_addr_q;
      REG_DST_ADDR:  rd_word = dst_addr_q;
      REG_VERSION:   rd_word = VERSION;
      default:       rd_word = 32'h0;
    endcase

    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = rd_err ? 32'h0 : rd_word;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
    arready_d = !rvalid_d;
  end

  always_ff @(posedge sys_clock) begin
    if (!reset_rtl) begin
      awready_q <= 1'b0;  wready_q <= 1'b0;  arready_q <= 1'b0;
      aw_held_q <= 1'b0;  awaddr_q <= '0;
      w_held_q  <= 1'b0;  wdata_q  <= '0;    wstrb_q   <= '0;
      bvalid_q  <= 1'b0;  bresp_q  <= '0;
      rvalid_q  <= 1'b0;  rresp_q  <= '0;    rdata_q   <= '0;
      start_q   <= 1'b0;  busy_q   <= 1'b0;  done_q    <= 1'b0;
      irq_en_q  <= 1'b0;  irq_q    <= 1'b0;  config_id_q <= '0;
      size_q    <= '0;    src_addr_q <= '0;  dst_addr_q  <= '0;
    end else begin
      awready_q <= awready_d;  wready_q <= wready_d;  arready_q <= arready_d;
      aw_held_q <= aw_held_d;  awaddr_q <= awaddr_d;
      w_held_q  <= w_held_d;   wdata_q  <= wdata_d;   wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;   bresp_q  <= bresp_d;
      rvalid_q  <= rvalid_d;   rresp_q  <= rresp_d;   rdata_q   <= rdata_d;
      start_q   <= start_d;    busy_q   <= busy_d;    done_q    <= done_d;
      irq_en_q  <= irq_en_d;   irq_q    <= irq_d;     config_id_q <= config_id_d;
      size_q    <= size_d;     src_addr_q <= src_addr_d; dst_addr_q <= dst_addr_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign irq_o         = irq_q;
  assign config_id_o   = config_id_q;
  assign size_o        = size_q;
  assign src_addr_o    = src_addr_q;
  assign dst_addr_o    = dst_addr_q;

endmodule

// File: tb/tb_mdc_axil_cfg_slave.sv
// Directed bench for mdc_axil_cfg_slave: register-map vector table plus
// hand-timed sequences for write latency, start/done, W1C race and reset.
module tb_mdc_axil_cfg_slave;

  localparam int AW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, done_i = 0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, start_o, busy_o, irq_o;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata, size_o, src_addr_o, dst_addr_o;
  logic [7:0]    config_id_o;

  int tests = 0, fails = 0, start_cnt = 0;

  mdc_axil_cfg_slave #(.ADDR_W(AW), .ID_W(8), .VERSION(32'h0001_0000)) dut (
    .sys_clock(clk), .reset_rtl(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .start_o(start_o), .config_id_o(config_id_o), .size_o(size_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
    .done_i(done_i), .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_o) start_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit awd = 0, wdn = 0, got = 0;
    int n = 0;
    resp = 2'bxx;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 0;
    while (!(awd && wdn) && n < 20) begin
      @(negedge clk);
      if (awvalid && awready) awd = 1;
      if (wvalid && wready) wdn = 1;
      tick;
      if (awd) awvalid = 0;
      if (wdn) wvalid = 0;
      n++;
    end
    if (!(awd && wdn)) begin
      awvalid = 0; wvalid = 0;
      tmo("write_addr_data");
      return;
    end
    bready = 1; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (bvalid) begin got = 1; resp = bresp; end
      tick;
      n++;
    end
    bready = 0;
    if (!got) tmo("write_resp");
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ard = 0, got = 0;
    int n = 0;
    d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1; rready = 0;
    while (!ard && n < 20) begin
      @(negedge clk);
      if (arready) ard = 1;
      tick;
      n++;
    end
    arvalid = 0;
    if (!ard) begin tmo("read_addr"); return; end
    rready = 1; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (rvalid) begin got = 1; d = rdata; resp = rresp; end
      tick;
      n++;
    end
    rready = 0;
    if (!got) tmo("read_data");
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          s0, bad;

    vt.push_back('{0, 8'h18, 32'h0,         4'h0, 2'b00, 32'h0001_0000, "rd_version"});
    vt.push_back('{0, 8'h04, 32'h0,         4'h0, 2'b00, 32'h0,         "rd_status_rst"});
    vt.push_back('{0, 8'h00, 32'h0,         4'h0, 2'b00, 32'h0,         "rd_ctrl_rst"});
    vt.push_back('{1, 8'h08, 32'h0000_00A5, 4'hF, 2'b00, 32'h0,         "wr_cfg"});
    vt.push_back('{0, 8'h08, 32'h0,         4'h0, 2'b00, 32'h0000_00A5, "rd_cfg"});
    vt.push_back('{1, 8'h08, 32'h1234_5678, 4'hF, 2'b00, 32'h0,         "wr_cfg_wide"});
    vt.push_back('{0, 8'h0B, 32'h0,         4'h0, 2'b00, 32'h0000_0078, "rd_cfg_trunc_lsb"});
    vt.push_back('{1, 8'h10, 32'h1122_3344, 4'hF, 2'b00, 32'h0,         "wr_src"});
    vt.push_back('{1, 8'h10, 32'hAABB_CCDD, 4'hA, 2'b00, 32'h0,         "wr_src_strb"});
    vt.push_back('{0, 8'h10, 32'h0,         4'h0, 2'b00, 32'hAA22_CC44, "rd_src_strb"});
    vt.push_back('{1, 8'h14, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0,         "wr_dst"});
    vt.push_back('{0, 8'h14, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D, "rd_dst"});
    vt.push_back('{1, 8'h1C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0,         "wr_rsvd"});
    vt.push_back('{0, 8'h1C, 32'h0,         4'h0, 2'b00, 32'h0,         "rd_rsvd"});
    vt.push_back('{1, 8'h18, 32'h0,         4'hF, 2'b00, 32'h0,         "wr_version"});
    vt.push_back('{0, 8'h18, 32'h0,         4'h0, 2'b00, 32'h0001_0000, "rd_version_ro"});
    vt.push_back('{1, 8'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0,         "wr_oob"});
    vt.push_back('{0, 8'h40, 32'h0,         4'h0, 2'b10, 32'h0,         "rd_oob"});
    vt.push_back('{1, 8'hE8, 32'h0000_0011, 4'hF, 2'b10, 32'h0,         "wr_oob_alias"});
    vt.push_back('{0, 8'h08, 32'h0,         4'h0, 2'b00, 32'h0000_0078, "rd_cfg_after_oob"});
    vt.push_back('{0, 8'h10, 32'h0,         4'h0, 2'b00, 32'hAA22_CC44, "rd_src_after_oob"});

    // reset state
    repeat (3) tick;
    @(negedge clk);
    chk("rst_readies", {29'h0, awready, wready, arready}, 32'h0);
    chk("rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
    chk("rst_ctl_out", {29'h0, start_o, busy_o, irq_o}, 32'h0);
    chk("rst_size", size_o, 32'h0);
    rst_n = 1;
    tick;
    @(negedge clk);
    chk("post_rst_readies", {29'h0, awready, wready, arready}, 32'h7);
    tick;

    foreach (vt[i]) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, r);
        chk({vt[i].name, "_bresp"}, 32'(r), 32'(vt[i].resp));
      end else begin
        axi_read(vt[i].addr, d, r);
        chk({vt[i].name, "_rresp"}, 32'(r), 32'(vt[i].resp));
        chk({vt[i].name, "_rdata"}, d, vt[i].rdata);
      end
    end
    chk("cfg_out", 32'(config_id_o), 32'h78);
    chk("src_out", src_addr_o, 32'hAA22_CC44);
    chk("dst_out", dst_addr_o, 32'hCAFE_F00D);

    // AW at cycle 0, W at cycle 3, bvalid at cycle 4; then hold bready low
    awaddr = 8'h0C; awvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'b0101; wvalid = 0; bready = 0;
    @(negedge clk); chk("lat_awready_c0", 32'(awready), 32'h1);
    tick; awvalid = 0;
    bad = 0;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk); if (bvalid || awready) bad++;
      tick;
    end
    chk("lat_wait_c1_c2", bad, 0);
    wvalid = 1;
    @(negedge clk);
    chk("lat_wready_c3", 32'(wready), 32'h1);
    chk("lat_bvalid_c3", 32'(bvalid), 32'h0);
    tick; wvalid = 0;
    @(negedge clk);
    chk("lat_bvalid_c4", 32'(bvalid), 32'h1);
    chk("lat_bresp", 32'(bresp), 32'h0);
    chk("lat_size", size_o, 32'h00AD_00EF);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick;
      @(negedge clk); if (!bvalid || awready || wready) bad++;
    end
    chk("bhold_5cyc", bad, 0);
    tick; bready = 1;
    @(negedge clk); chk("bhold_still_valid", 32'(bvalid), 32'h1);
    tick; bready = 0;
    @(negedge clk);
    chk("bhs_bvalid_low", 32'(bvalid), 32'h0);
    chk("bhs_ready_back", {30'h0, awready, wready}, 32'h3);
    tick;

    // start / busy / done / irq
    s0 = start_cnt;
    axi_write(8'h00, 32'h3, 4'hF, r);
    tick;
    chk("start_pulse_cnt", start_cnt - s0, 1);
    chk("busy_after_start", 32'(busy_o), 32'h1);
    s0 = start_cnt;
    axi_write(8'h00, 32'h1, 4'hF, r);
    tick;
    chk("no_start_busy", start_cnt - s0, 0);
    axi_read(8'h00, d, r);
    chk("ctrl_irqen_cleared", d, 32'h0);
    axi_write(8'h00, 32'h2, 4'hF, r);
    axi_read(8'h00, d, r);
    chk("ctrl_irqen_set", d, 32'h2);
    done_i = 1; tick; done_i = 0; tick;
    chk("busy_after_done", 32'(busy_o), 32'h0);
    chk("irq_after_done", 32'(irq_o), 32'h1);
    axi_read(8'h04, d, r);
    chk("status_done", d, 32'h2);
    s0 = start_cnt;
    axi_write(8'h00, 32'h3, 4'hE, r);
    tick;
    chk("no_start_strb0_off", start_cnt - s0, 0);
    chk("irq_kept_strb0_off", 32'(irq_o), 32'h1);

    // W1C of done on the same edge as done_i: set wins
    awaddr = 8'h04; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; done_i = 1;
    @(negedge clk); chk("w1c_race_readies", {30'h0, awready, wready}, 32'h3);
    tick; awvalid = 0; wvalid = 0; done_i = 0;
    @(negedge clk); chk("w1c_race_bvalid", 32'(bvalid), 32'h1);
    tick; bready = 0;
    axi_read(8'h04, d, r);
    chk("w1c_race_status", d, 32'h2);
    chk("w1c_race_irq", 32'(irq_o), 32'h1);
    axi_write(8'h04, 32'h2, 4'hF, r);
    axi_read(8'h04, d, r);
    chk("w1c_status", d, 32'h0);
    chk("w1c_irq", 32'(irq_o), 32'h0);
    s0 = start_cnt;
    axi_write(8'h00, 32'h3, 4'hF, r);
    tick;
    chk("restart_pulse", start_cnt - s0, 1);
    chk("restart_busy", 32'(busy_o), 32'h1);

    // reset with AW held and a read response pending
    awaddr = 8'h0C; awvalid = 1; araddr = 8'h18; arvalid = 1; rready = 0;
    tick; awvalid = 0; arvalid = 0;
    @(negedge clk);
    chk("pre_rst_pending", {30'h0, rvalid, awready}, 32'h2);
    tick; rst_n = 0;
    tick;
    @(negedge clk);
    chk("mid_rst_handshake", {25'h0, awready, wready, arready, bvalid, rvalid, bresp}, 32'h0);
    chk("mid_rst_ctl", {28'h0, start_o, busy_o, irq_o, |rresp}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_cfg", {size_o | src_addr_o | dst_addr_o | 32'(config_id_o)}, 32'h0);
    rst_n = 1;
    tick;
    @(negedge clk);
    chk("post_mid_rst_readies", {29'h0, awready, wready, arready}, 32'h7);
    tick;
    axi_read(8'h0C, d, r);
    chk("post_mid_rst_size", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
